// File: rtl/ysyx_24110015_csr_file.sv
// Machine-mode CSR file: access port (CSRRW/RS/RC), trap entry and mret sequencing.
// Optional 64-bit mcycle/minstret counters under `YSYX_24110015_CSR_COUNTERS_EN.
module ysyx_24110015_csr_file #(
   parameter int                MSTATUS_RST_W = 32,
   parameter int                XLEN          = 32,
   parameter logic [XLEN-1:0]   MSTATUS_RST   = 32'h00001800,
   parameter logic [XLEN-1:0]   MVENDORID     = 32'h79737978,
   parameter logic [XLEN-1:0]   MARCHID       = 32'd24110015
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            csr_valid,
   input  logic [11:0]     csr_addr,
   input  logic [1:0]      csr_op,
   input  logic            csr_wen,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_cause,
   input  logic            mret_valid,
   input  logic            instret_inc,
   output logic [XLEN-1:0] trap_target,
   output logic [XLEN-1:0] mret_target,
   output logic            mie_out
);

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MVENDORID = 12'hF11;
   localparam logic [11:0] A_MARCHID   = 12'hF12;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   function automatic logic [XLEN-1:0] csr_wdata_calc(input logic [1:0] op,
                                                      input logic [XLEN-1:0] old,
                                                      input logic [XLEN-1:0] src);
      case (op)
         2'b01:   return src;
         2'b10:   return old | src;
         2'b11:   return old & ~src;
         default: return old;
      endcase
   endfunction

   logic            mie, mpie;
   logic [XLEN-1:0] mtvec, mepc, mcause;
   logic [XLEN-1:0] mstatus_val;
   logic            impl;
   logic [XLEN-1:0] old_val;
   logic [XLEN-1:0] new_val;
   logic            wr_req, wr_en;

`ifdef YSYX_24110015_CSR_COUNTERS_EN
   logic [2*XLEN-1:0] mcycle, minstret;
`else
   logic unused_instret;
   assign unused_instret = instret_inc;
`endif

   // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
   always_comb begin
      mstatus_val        = '0;
      mstatus_val[12:11] = 2'b11;
      mstatus_val[7]     = mpie;
      mstatus_val[3]     = mie;
   end

   always_comb begin
      impl    = 1'b1;
      old_val = '0;
      case (csr_addr)
         A_MSTATUS:   old_val = mstatus_val;
         A_MTVEC:     old_val = mtvec;
         A_MEPC:      old_val = mepc;
         A_MCAUSE:    old_val = mcause;
         A_MVENDORID: old_val = MVENDORID;
         A_MARCHID:   old_val = MARCHID;
`ifdef YSYX_24110015_CSR_COUNTERS_EN
         A_MCYCLE:    old_val = mcycle[XLEN-1:0];
         A_MCYCLEH:   old_val = mcycle[2*XLEN-1:XLEN];
         A_MINSTRET:  old_val = minstret[XLEN-1:0];
         A_MINSTRETH: old_val = minstret[2*XLEN-1:XLEN];
`endif
         default:     impl = 1'b0;
      endcase
   end

   assign csr_illegal = csr_valid & (~impl | (csr_wen & (csr_addr[11:10] == 2'b11)));
   assign csr_rdata   = (csr_valid & impl) ? old_val : '0;
   assign new_val     = csr_wdata_calc(csr_op, old_val, csr_wdata);
   assign wr_req      = csr_valid & csr_wen & (csr_op != 2'b00) & ~csr_illegal;
   // Trap and mret both outrank the access port; a losing write is simply dropped.
   assign wr_en       = wr_req & ~trap_valid & ~mret_valid;

   assign trap_target = mtvec;
   assign mret_target = mepc;
   assign mie_out     = mie;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mie    <= MSTATUS_RST[3];
         mpie   <= MSTATUS_RST[7];
         mtvec  <= '0;
         mepc   <= '0;
         mcause <= '0;
      end else if (trap_valid) begin
         mepc   <= trap_pc & ALIGN_MASK;
         mcause <= trap_cause;
         mpie   <= mie;
         mie    <= 1'b0;
      end else if (mret_valid) begin
         mie    <= mpie;
         mpie   <= 1'b1;
      end else if (wr_en) begin
         case (csr_addr)
            A_MSTATUS: begin
               mie  <= new_val[3];
               mpie <= new_val[7];
            end
            A_MTVEC:  mtvec  <= new_val & ALIGN_MASK;
            A_MEPC:   mepc   <= new_val & ALIGN_MASK;
            A_MCAUSE: mcause <= new_val;
            default:  ;
         endcase
      end
   end

`ifdef YSYX_24110015_CSR_COUNTERS_EN
   logic wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
   assign wr_cyc_lo = wr_en & (csr_addr == A_MCYCLE);
   assign wr_cyc_hi = wr_en & (csr_addr == A_MCYCLEH);
   assign wr_ins_lo = wr_en & (csr_addr == A_MINSTRET);
   assign wr_ins_hi = wr_en & (csr_addr == A_MINSTRETH);

   // A write to either half replaces it and skips that counter's increment this cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         if (wr_cyc_lo)      mcycle[XLEN-1:0]        <= new_val;
         else if (wr_cyc_hi) mcycle[2*XLEN-1:XLEN]   <= new_val;
         else                mcycle                  <= mcycle + 1'b1;
         if (wr_ins_lo)        minstret[XLEN-1:0]      <= new_val;
         else if (wr_ins_hi)   minstret[2*XLEN-1:XLEN] <= new_val;
         else if (instret_inc) minstret                <= minstret + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_24110015_csr_file.sv
// Self-checking bench for ysyx_24110015_csr_file: directed cases plus random traffic
// checked every cycle against a behavioural CSR model.
module tb_ysyx_24110015_csr_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_valid;
   logic [11:0] csr_addr;
   logic [1:0]  csr_op;
   logic        csr_wen;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        trap_valid;
   logic [31:0] trap_pc;
   logic [31:0] trap_cause;
   logic        mret_valid;
   logic        instret_inc;
   logic [31:0] trap_target;
   logic [31:0] mret_target;
   logic        mie_out;

   int total = 0;
   int bad   = 0;

   ysyx_24110015_csr_file dut (
      .clk(clk), .rst(rst),
      .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wen(csr_wen),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
      .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
      .mret_valid(mret_valid), .instret_inc(instret_inc),
      .trap_target(trap_target), .mret_target(mret_target), .mie_out(mie_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: architectural state only.
   bit        m_mie, m_mpie;
   bit [31:0] m_mtvec, m_mepc, m_mcause;
   bit [63:0] m_mcycle, m_minstret;

   function automatic bit [31:0] m_mstatus();
      return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
   endfunction

   task automatic m_read(input logic [11:0] a, output bit impl, output bit [31:0] v);
      impl = 1'b1;
      v    = 32'h0;
      case (a)
         12'h300: v = m_mstatus();
         12'h305: v = m_mtvec;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'hF11: v = 32'h79737978;
         12'hF12: v = 32'd24110015;
`ifdef YSYX_24110015_CSR_COUNTERS_EN
         12'hB00: v = m_mcycle[31:0];
         12'hB80: v = m_mcycle[63:32];
         12'hB02: v = m_minstret[31:0];
         12'hB82: v = m_minstret[63:32];
`endif
         default: impl = 1'b0;
      endcase
   endtask

   function automatic bit m_illegal(input bit impl);
      return csr_valid && (!impl || (csr_wen && csr_addr[11:10] == 2'b11));
   endfunction

   task automatic model_check();
      bit impl;
      bit [31:0] v;
      m_read(csr_addr, impl, v);
      chk("rdata", csr_rdata, (csr_valid && impl) ? v : 32'h0);
      chk("illegal", {31'b0, csr_illegal}, {31'b0, m_illegal(impl)});
      chk("trap_target", trap_target, m_mtvec);
      chk("mret_target", mret_target, m_mepc);
      chk("mie_out", {31'b0, mie_out}, {31'b0, m_mie});
   endtask

   // Computes the next architectural state from the inputs held across the edge.
   task automatic model_update();
      bit impl, do_wr, cyc_wr, ins_wr;
      bit [31:0] v, nv;
      m_read(csr_addr, impl, v);
      do_wr = csr_valid && csr_wen && csr_op != 2'b00 && !m_illegal(impl)
              && !trap_valid && !mret_valid;
      case (csr_op)
         2'b01:   nv = csr_wdata;
         2'b10:   nv = v | csr_wdata;
         2'b11:   nv = v & ~csr_wdata;
         default: nv = v;
      endcase
      cyc_wr = 1'b0;
      ins_wr = 1'b0;
      if (trap_valid) begin
         m_mepc   = {trap_pc[31:2], 2'b00};
         m_mcause = trap_cause;
         m_mpie   = m_mie;
         m_mie    = 1'b0;
      end else if (mret_valid) begin
         m_mie  = m_mpie;
         m_mpie = 1'b1;
      end else if (do_wr) begin
         case (csr_addr)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h305: m_mtvec  = {nv[31:2], 2'b00};
            12'h341: m_mepc   = {nv[31:2], 2'b00};
            12'h342: m_mcause = nv;
            12'hB00: begin m_mcycle[31:0]    = nv; cyc_wr = 1'b1; end
            12'hB80: begin m_mcycle[63:32]   = nv; cyc_wr = 1'b1; end
            12'hB02: begin m_minstret[31:0]  = nv; ins_wr = 1'b1; end
            12'hB82: begin m_minstret[63:32] = nv; ins_wr = 1'b1; end
            default: ;
         endcase
      end
      if (!cyc_wr) m_mcycle = m_mcycle + 64'd1;
      if (!ins_wr && instret_inc) m_minstret = m_minstret + 64'd1;
   endtask

   task automatic set_in(input bit v, input logic [11:0] a, input logic [1:0] op,
                         input bit wen, input logic [31:0] wd);
      csr_valid = v;
      csr_addr  = a;
      csr_op    = op;
      csr_wen   = wen;
      csr_wdata = wd;
   endtask

   task automatic idle();
      set_in(1'b0, 12'h0, 2'b00, 1'b0, 32'h0);
      trap_valid  = 1'b0;
      trap_pc     = 32'h0;
      trap_cause  = 32'h0;
      mret_valid  = 1'b0;
      instret_inc = 1'b0;
   endtask

   task automatic tick();
      #1;
      model_check();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] exp);
      idle();
      set_in(1'b1, a, 2'b00, 1'b0, 32'h0);
      #1;
      chk(tag, csr_rdata, exp);
      tick();
   endtask

   logic [11:0] addrs [12] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12,
                               12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h123, 12'h301};

   initial begin
      idle();
      rst = 1'b0;
      m_mie = 1'b0; m_mpie = 1'b0;
      m_mtvec = '0; m_mepc = '0; m_mcause = '0; m_mcycle = '0; m_minstret = '0;
      repeat (3) @(negedge clk);
      set_in(1'b1, 12'h300, 2'b00, 1'b0, 32'h0);
      #1;
      chk("rst_rdata_busy_in_reset", csr_rdata, 32'h1800);
      idle();
      #1;
      chk("rst_rdata", csr_rdata, 32'h0);
      chk("rst_illegal", {31'b0, csr_illegal}, 32'h0);
      chk("rst_mie", {31'b0, mie_out}, 32'h0);
      chk("rst_mtvec", trap_target, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      rd(12'h300, "t1_mstatus", 32'h00001800);
      rd(12'hF11, "t1_mvendorid", 32'h79737978);
      rd(12'hF12, "t1_marchid", 32'd24110015);

      idle(); set_in(1'b1, 12'h305, 2'b01, 1'b1, 32'h80000007);
      #1; chk("t2_rw_old", csr_rdata, 32'h0);
      tick();
      rd(12'h305, "t2_mtvec", 32'h80000004);
      chk("t2_trap_target", trap_target, 32'h80000004);
      idle(); set_in(1'b1, 12'h300, 2'b10, 1'b1, 32'h8); tick();
      idle(); #1; chk("t2_mie_set", {31'b0, mie_out}, 32'h1); tick();
      idle(); set_in(1'b1, 12'h300, 2'b11, 1'b1, 32'h8); tick();
      idle(); #1; chk("t2_mie_clr", {31'b0, mie_out}, 32'h0); tick();

      idle(); set_in(1'b1, 12'h300, 2'b10, 1'b1, 32'h8); tick();
      idle(); trap_valid = 1'b1; trap_pc = 32'h80000102; trap_cause = 32'd11; tick();
      rd(12'h341, "t3_mepc", 32'h80000100);
      rd(12'h342, "t3_mcause", 32'd11);
      rd(12'h300, "t3_mstatus", 32'h1880);
      idle(); mret_valid = 1'b1; tick();
      rd(12'h300, "t3_mret_mstatus", 32'h1888);
      chk("t3_mret_target", mret_target, 32'h80000100);

      idle(); set_in(1'b1, 12'h342, 2'b01, 1'b1, 32'd5);
      trap_valid = 1'b1; trap_pc = 32'h00000200; trap_cause = 32'd7; mret_valid = 1'b1;
      tick();
      rd(12'h342, "t4_mcause", 32'd7);
      rd(12'h300, "t4_mstatus", 32'h1880);
      rd(12'h341, "t4_mepc", 32'h200);

      idle(); set_in(1'b1, 12'hF11, 2'b01, 1'b1, 32'h5);
      #1; chk("t5_ro_write_ill", {31'b0, csr_illegal}, 32'h1);
      tick();
      rd(12'hF11, "t5_ro_kept", 32'h79737978);
      idle(); set_in(1'b1, 12'h123, 2'b00, 1'b0, 32'h0);
      #1; chk("t5_unimpl_ill", {31'b0, csr_illegal}, 32'h1);
      chk("t5_unimpl_rdata", csr_rdata, 32'h0);
      tick();
      idle(); set_in(1'b1, 12'hF11, 2'b10, 1'b0, 32'h0);
      #1; chk("t5_rs_x0_legal", {31'b0, csr_illegal}, 32'h0);
      tick();

`ifdef YSYX_24110015_CSR_COUNTERS_EN
      idle(); set_in(1'b1, 12'hB00, 2'b01, 1'b1, 32'hFFFFFFFF); tick();
      idle(); set_in(1'b1, 12'hB80, 2'b01, 1'b1, 32'hFFFFFFFF); tick();
      idle(); tick();
      rd(12'hB80, "t6_mcycleh_wrap", 32'h0);
`else
      idle(); set_in(1'b1, 12'hB00, 2'b00, 1'b0, 32'h0);
      #1; chk("t6_b00_ill", {31'b0, csr_illegal}, 32'h1);
      chk("t6_b00_rdata", csr_rdata, 32'h0);
      tick();
`endif

      for (int i = 0; i < 600; i++) begin
         idle();
         set_in(($urandom_range(0, 3) != 0), addrs[$urandom_range(0, 11)],
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
         trap_valid  = ($urandom_range(0, 15) == 0);
         trap_pc     = $urandom;
         trap_cause  = $urandom;
         mret_valid  = ($urandom_range(0, 15) == 0);
         instret_inc = 1'($urandom_range(0, 1));
         tick();
      end

      idle();
      rst = 1'b0;
      #1;
      chk("rst2_mtvec", trap_target, 32'h0);
      chk("rst2_mepc", mret_target, 32'h0);
      chk("rst2_mie", {31'b0, mie_out}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
